// File: rtl/image_mem_pkg.sv
// Shared types and widths for the processed-image memory path.
// Both the VGA fetch and CPU load/store sides use these definitions.
package image_mem_pkg;

  localparam int IMG_ADDR_W = 18;
  localparam int IMG_DATA_W = 8;

  typedef logic [IMG_ADDR_W-1:0] img_addr_t;

  // Which requester is waiting for data on the memory port this cycle
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VGA_PEND = 2'd1,
    CPU_PEND = 2'd2
  } owner_t;

endpackage

// File: rtl/image_mem_arbiter_sat_counter.sv
// Saturating up-counter with a synchronous clear.
// The clear has priority over the increment.
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/image_mem_arbiter.sv
// Arbiter for the single-port image memory shared by VGA pixel fetch and CPU.
// VGA wins by default; a starvation timer forces a CPU slot after MAX_WAIT cycles.
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | no read outstanding on the memory port
// VGA_PEND | VGA read issued last cycle, mem_rdata goes to VGA
// CPU_PEND | CPU read issued last cycle, mem_rdata goes to CPU
module image_mem_arbiter
  import image_mem_pkg::*;
#(
  parameter int ADDR_W   = IMG_ADDR_W,
  parameter int DATA_W   = IMG_DATA_W,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_enb,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_miss,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              miss_clr,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int               WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  owner_t              owner_q, owner_d;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                miss_q;
  logic                v, ovr, grant_vga, grant_cpu, miss_now;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      miss_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      miss_q  <= miss_now;
      if (grant_vga || grant_cpu) begin
        addr_q <= mem_addr;
      end
      if (grant_cpu) begin
        wdata_q <= cpu_wdata;
      end
    end
  end

  always_comb begin
    v         = vga_req & vga_enb;
    ovr       = cpu_req & (wait_cnt >= WAIT_MAX);
    grant_vga = v & ~ovr;
    grant_cpu = cpu_req & (~v | ovr);
    miss_now  = v & ovr;
    cpu_ack   = grant_cpu;
    owner_d   = IDLE;
    // Idle cycles keep the previous address on the bus to avoid toggling
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wdata = wdata_q;
    if (grant_vga) begin
      mem_addr = vga_addr;
      owner_d  = VGA_PEND;
    end else if (grant_cpu) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
      owner_d   = cpu_we ? IDLE : CPU_PEND;
    end
  end

  always_comb begin
    vga_rvalid = (owner_q == VGA_PEND);
    cpu_rvalid = (owner_q == CPU_PEND);
    vga_miss   = miss_q;
    vga_rdata  = vga_rvalid ? mem_rdata : '0;
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  end

  sat_counter #(
    .WIDTH (WAIT_W),
    .MAX   (WAIT_MAX)
  ) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cpu_ack | ~cpu_req),
    .inc   (cpu_req),
    .count (wait_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (miss_clr),
    .inc   (miss_now),
    .count (miss_count)
  );

endmodule
